led_seq_ctrl: RTL

Pattern sequencer and scheduler for the two board LEDs. It owns the step prescaler, holds the current display mode, and advances the 2-bit LED pattern once per step period. A host (key handler or register interface) requests mode changes over a valid/ready handshake; requests are applied only on step boundaries so patterns never glitch mid-period.

---
 rtl/led_pkg.sv | 52 +++++
 rtl/led_tick_gen.sv | 44 ++++
 rtl/led_seq_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// ============================================================================
// led_pkg : shared types and pattern helpers for the two-LED sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ALT   = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_CHASE = 2'd3
    } led_mode_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } led_state_t;

    function automatic logic [1:0] led_init(input led_mode_t mode);
        case (mode)
            MODE_ALT:   return 2'b01;
            MODE_BLINK: return 2'b11;
            MODE_CHASE: return 2'b01;
            default:    return 2'b00;
        endcase
    endfunction

    // Off-sequence values fall back to the mode's start so a pattern always resyncs.
    function automatic logic [1:0] led_next(input led_mode_t mode, input logic [1:0] led);
        logic [1:0] nxt;
        nxt = 2'b00;
        case (mode)
            MODE_ALT:   nxt = (led == 2'b01) ? 2'b10 : 2'b01;
            MODE_BLINK: nxt = (led == 2'b11) ? 2'b00 : 2'b11;
            MODE_CHASE: begin
                case (led)
                    2'b01:   nxt = 2'b11;
                    2'b11:   nxt = 2'b10;
                    2'b10:   nxt = 2'b00;
                    default: nxt = 2'b01;
                endcase
            end
            default:    nxt = 2'b00;
        endcase
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_tick_gen.sv
// ============================================================================
// led_tick_gen : step prescaler, one-cycle tick every TICK_CNT enabled cycles
// Revision: 1.0
// ============================================================================
`default_nettype none

module led_tick_gen #(
    parameter int TICK_CNT = 25_000_000,
    parameter int CW       = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [CW-1:0] C_LAST = CW'(TICK_CNT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && !rst && !clr && (cnt_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/led_seq_ctrl.sv
// ============================================================================
// led_seq_ctrl : LED pattern sequencer; mode requests take effect on step ticks
// Revision: 1.0
// ============================================================================
`default_nettype none

module led_seq_ctrl
    import led_pkg::*;
#(
    parameter int TICK_CNT = 25_000_000,
    parameter int CW       = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       mode_valid,
    input  logic [1:0] mode_data,
    output logic       mode_ready,
    output logic [1:0] led,
    output logic       tick,
    output logic       busy
);

    led_state_t state_q;
    led_mode_t  mode_q;
    led_mode_t  pend_mode_q;
    logic       pend_q;
    logic [1:0] led_q;
    logic       busy_q;

    logic       w_tick;
    logic       w_accept;
    led_mode_t  w_req_mode;

    assign mode_ready = !rst && !pend_q;
    assign w_accept   = mode_valid && mode_ready;
    assign w_req_mode = led_mode_t'(mode_data);

    led_tick_gen #(
        .TICK_CNT (TICK_CNT),
        .CW       (CW)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q == ST_IDLE),
        .en   (en),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_OFF;
            pend_mode_q <= MODE_OFF;
            pend_q      <= 1'b0;
            led_q       <= 2'b00;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    led_q <= 2'b00;
                    if (w_accept && (w_req_mode != MODE_OFF)) begin
                        mode_q  <= w_req_mode;
                        led_q   <= led_init(w_req_mode);
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // A request accepted on a tick cycle only lands in pend here,
                    // so that tick still advances the old pattern.
                    if (w_tick) begin
                        if (!pend_q) begin
                            led_q <= led_next(mode_q, led_q);
                        end else if (pend_mode_q == MODE_OFF) begin
                            led_q   <= 2'b00;
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            pend_q  <= 1'b0;
                        end else begin
                            mode_q <= pend_mode_q;
                            led_q  <= led_init(pend_mode_q);
                            pend_q <= 1'b0;
                        end
                    end
                    if (w_accept) begin
                        pend_q      <= 1'b1;
                        pend_mode_q <= w_req_mode;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    led_q   <= 2'b00;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign led  = led_q;
    assign busy = busy_q;
    assign tick = w_tick;

endmodule

`default_nettype wire
